// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and default sizing for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_t;

    localparam int DEF_N_REQ       = 3;
    localparam int DEF_GAP_TIMEOUT = 1024;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req bit at or after ptr, wrapping
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PTR_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win
);

    int   idx;
    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - packet-level round-robin arbiter feeding bytes from N requesters to one UART transmitter
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant,
    output logic               gap_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_MAX   = '1;
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

    arb_state_t       state, state_next;
    logic [N_REQ-1:0] grant_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic [PTR_W-1:0] owner, owner_next, owner_inc;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
    logic             last_q, last_next;
    logic             gap_err_next;

    logic [N_REQ-1:0] win;
    logic [PTR_W-1:0] win_idx;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       owner_data;
    logic             handshake;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr),
        .win (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == PTR_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[8*i +: 8];
            end
        end
    end

    assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    // The byte is offered only when the transmitter is free; reset masks the strobe outright.
    assign handshake = (state == ISSUE) && !tx_busy && owner_valid && !rst;
    assign tx_start  = handshake;
    assign tx_data   = handshake ? owner_data : 8'h00;
    assign req_ready = handshake ? grant : '0;

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        ptr_next     = ptr;
        owner_next   = owner;
        gap_cnt_next = gap_cnt;
        last_next    = last_q;
        gap_err_next = 1'b0;
        case (state)
            IDLE: begin
                gap_cnt_next = '0;
                if (en && |req_valid) begin
                    grant_next = win;
                    owner_next = win_idx;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    last_next    = owner_last;
                    gap_cnt_next = '0;
                    state_next   = WAIT_HI;
                end else if (!owner_valid) begin
                    if (gap_cnt >= GAP_LIMIT) begin
                        grant_next   = '0;
                        gap_err_next = 1'b1;
                        ptr_next     = owner_inc;
                        gap_cnt_next = '0;
                        last_next    = 1'b0;
                        state_next   = IDLE;
                    end else if (gap_cnt != GAP_MAX) begin
                        gap_cnt_next = gap_cnt + 1'b1;
                    end
                end
            end
            WAIT_HI: begin
                if (tx_busy) state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_next = '0;
                        ptr_next   = owner_inc;
                        last_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            owner   <= '0;
            gap_cnt <= '0;
            last_q  <= 1'b0;
            gap_err <= 1'b0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            ptr     <= ptr_next;
            owner   <= owner_next;
            gap_cnt <= gap_cnt_next;
            last_q  <= last_next;
            gap_err <= gap_err_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed self-checking bench for uart_tx_arb with a behavioural transmitter
module tb_uart_tx_arb;

    localparam int N        = 3;
    localparam int BUSY_LEN = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           gap_err;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N_REQ       (N),
        .GAP_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .gap_err   (gap_err)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic rst_set = 1'b1;
    logic en_set = 1'b0;

    logic [7:0] q_data [N][32];
    logic       q_last [N][32];
    int         q_head [N];
    int         q_tail [N];

    logic [7:0] log_data [64];
    int         log_own [64];
    int         log_cyc [64];
    int         log_n = 0;

    int busy_cnt = 0;
    int viol_busy = 0;
    int viol_ready = 0;
    int viol_onehot = 0;
    int gap_seen = 0;
    int gap_cyc = -1;
    logic [N-1:0] gap_grant = '0;

    function automatic int idx_of(input logic [N-1:0] g);
        int r = -1;
        int c = 0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                r = i;
                c++;
            end
        end
        if (c > 1) r = -2;
        return r;
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            q_head[i] = 0;
            q_tail[i] = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        q_data[r][q_tail[r]] = d;
        q_last[r][q_tail[r]] = l;
        q_tail[r]++;
    endtask

    // One clock: apply staged inputs at the falling edge, observe 1 ns later.
    task automatic tick();
        @(negedge clk);
        cyc++;
        rst = rst_set;
        en  = en_set;
        if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            tx_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (q_head[i] < q_tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q_data[i][q_head[i]];
                req_last[i]        = q_last[i][q_head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        #1;
        if (tx_start) begin
            if (tx_busy) viol_busy++;
            if (idx_of(req_ready & req_valid) < 0) viol_ready++;
            if (log_n < 64) begin
                log_data[log_n] = tx_data;
                log_own[log_n]  = idx_of(grant);
                log_cyc[log_n]  = cyc;
                log_n++;
            end
            busy_cnt = BUSY_LEN;
        end
        if (grant != '0 && idx_of(grant) < 0) viol_onehot++;
        if ((req_ready & ~grant) != '0) viol_ready++;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) q_head[i]++;
        end
        if (gap_err) begin
            gap_seen++;
            gap_cyc   = cyc;
            gap_grant = grant;
        end
    endtask

    task automatic do_reset();
        rst_set = 1'b1;
        en_set  = 1'b1;
        clear_queues();
        for (int k = 0; k < 3; k++) tick();
        for (int k = 0; k < 20 && busy_cnt > 0; k++) tick();
        rst_set  = 1'b0;
        log_n    = 0;
        gap_seen = 0;
        gap_cyc  = -1;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick();
            if (log_n >= n && grant == '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_set = 1'b1;
        en_set  = 1'b1;
        clear_queues();
        push(0, 8'hAA, 1'b1);
        push(1, 8'hBB, 1'b1);
        tick();
        tick();
        n_checks++;
        if (grant !== 3'b000) $display("FAIL reset_grant: got %b expected 000", grant);
        else n_pass++;
        n_checks++;
        if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", tx_start);
        else n_pass++;
        n_checks++;
        if (req_ready !== 3'b000) $display("FAIL reset_req_ready: got %b expected 000", req_ready);
        else n_pass++;
        n_checks++;
        if (gap_err !== 1'b0) $display("FAIL reset_gap_err: got %b expected 0", gap_err);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3] = '{8'h41, 8'h42, 8'h43};
        int  t0;
        int  bad = 0;
        bit  done = 1'b0;
        do_reset();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        t0 = cyc + 1;
        for (int k = 0; k < 80 && !done; k++) begin
            tick();
            if (log_n >= 1 && log_n < 3 && grant !== 3'b001) bad++;
            if (log_n >= 3 && grant == '0) done = 1'b1;
        end
        n_checks++;
        if (!done || log_n != 3) $display("FAIL single_done: got done=%0d bytes=%0d expected done=1 bytes=3", done, log_n);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (log_data[i] !== exp_d[i] || log_own[i] != 0)
                $display("FAIL single_byte%0d: got own=%0d data=%h expected own=0 data=%h", i, log_own[i], log_data[i], exp_d[i]);
            else n_pass++;
        end
        n_checks++;
        if (log_cyc[0] != t0 + 1) $display("FAIL single_latency: got cycle %0d expected %0d", log_cyc[0], t0 + 1);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL single_grant_held: got %0d cycles with grant not 001 expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h20, 8'h21};
        int         exp_o [4] = '{0, 0, 2, 2};
        bit ok;
        do_reset();
        push(0, 8'h10, 1'b0);
        push(0, 8'h11, 1'b1);
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b1);
        wait_done(4, 120, ok);
        n_checks++;
        if (!ok) $display("FAIL contention_done: got bytes=%0d expected 4", log_n);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_data[i] !== exp_d[i] || log_own[i] != exp_o[i])
                $display("FAIL contention_byte%0d: got own=%0d data=%h expected own=%0d data=%h", i, log_own[i], log_data[i], exp_o[i], exp_d[i]);
            else n_pass++;
        end
        // ptr back at 0: with req0 and req1 both pending, req0 must win first.
        push(0, 8'h30, 1'b1);
        push(1, 8'h31, 1'b1);
        wait_done(6, 80, ok);
        n_checks++;
        if (!ok || log_own[4] != 0 || log_own[5] != 1)
            $display("FAIL contention_ptr: got owners %0d,%0d expected 0,1", log_own[4], log_own[5]);
        else n_pass++;
    endtask

    task automatic test_fairness();
        int         exp_o [6] = '{0, 1, 2, 0, 1, 2};
        logic [7:0] exp_d [6] = '{8'h60, 8'h61, 8'h62, 8'h70, 8'h71, 8'h72};
        bit ok;
        do_reset();
        for (int r = 0; r < N; r++) begin
            push(r, 8'h60 + 8'(r), 1'b1);
            push(r, 8'h70 + 8'(r), 1'b1);
        end
        wait_done(6, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL fairness_done: got bytes=%0d expected 6", log_n);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (log_own[i] != exp_o[i] || log_data[i] !== exp_d[i])
                $display("FAIL fairness_grant%0d: got own=%0d data=%h expected own=%0d data=%h", i, log_own[i], log_data[i], exp_o[i], exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_gap_timeout();
        bit ok;
        do_reset();
        push(1, 8'h55, 1'b0);
        push(2, 8'h66, 1'b1);
        wait_done(2, 200, ok);
        n_checks++;
        if (!ok) $display("FAIL gap_done: got bytes=%0d expected 2", log_n);
        else n_pass++;
        n_checks++;
        if (log_own[0] != 1 || log_data[0] !== 8'h55)
            $display("FAIL gap_first: got own=%0d data=%h expected own=1 data=55", log_own[0], log_data[0]);
        else n_pass++;
        n_checks++;
        if (gap_seen != 1) $display("FAIL gap_pulses: got %0d expected 1", gap_seen);
        else n_pass++;
        // start at S, busy S+1..S+3, back in ISSUE at S+5, 8 idle ISSUE cycles -> pulse at S+13
        n_checks++;
        if (gap_cyc != log_cyc[0] + 13) $display("FAIL gap_timing: got cycle %0d expected %0d", gap_cyc, log_cyc[0] + 13);
        else n_pass++;
        n_checks++;
        if (gap_grant !== 3'b000) $display("FAIL gap_grant_clear: got %b expected 000", gap_grant);
        else n_pass++;
        n_checks++;
        if (log_own[1] != 2 || log_data[1] !== 8'h66 || log_cyc[1] != gap_cyc + 1)
            $display("FAIL gap_next: got own=%0d data=%h cycle=%0d expected own=2 data=66 cycle=%0d", log_own[1], log_data[1], log_cyc[1], gap_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_enable();
        bit ok = 1'b0;
        int quiet = 0;
        int t;
        do_reset();
        push(0, 8'h31, 1'b0);
        push(0, 8'h32, 1'b1);
        push(1, 8'h41, 1'b1);
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (log_n >= 1) ok = 1'b1;
        end
        en_set = 1'b0;
        wait_done(2, 60, ok);
        n_checks++;
        if (!ok || log_own[1] != 0 || log_data[1] !== 8'h32)
            $display("FAIL enable_complete: got own=%0d data=%h expected own=0 data=32", log_own[1], log_data[1]);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant != '0 || tx_start) quiet++;
        end
        n_checks++;
        if (quiet != 0 || log_n != 2) $display("FAIL enable_blocked: got %0d active cycles, %0d bytes expected 0, 2", quiet, log_n);
        else n_pass++;
        en_set = 1'b1;
        tick();
        t = cyc;
        wait_done(3, 40, ok);
        n_checks++;
        if (!ok || log_own[2] != 1 || log_data[2] !== 8'h41 || log_cyc[2] != t + 1)
            $display("FAIL enable_resume: got own=%0d data=%h cycle=%0d expected own=1 data=41 cycle=%0d", log_own[2], log_data[2], log_cyc[2], t + 1);
        else n_pass++;
    endtask

    task automatic test_reset_wait_lo();
        bit ok = 1'b0;
        int busy_grant = 0;
        do_reset();
        push(0, 8'h51, 1'b0);
        push(0, 8'h52, 1'b1);
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (log_n >= 1) ok = 1'b1;
        end
        tick();
        tick();
        rst_set = 1'b1;
        clear_queues();
        tick();
        rst_set = 1'b0;
        tick();
        n_checks++;
        if (grant !== 3'b000) $display("FAIL rst_wait_lo_grant: got %b expected 000", grant);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (grant != '0) busy_grant++;
        end
        n_checks++;
        if (log_n != 1 || busy_grant != 0) $display("FAIL rst_wait_lo_quiet: got bytes=%0d grant_cycles=%0d expected 1, 0", log_n, busy_grant);
        else n_pass++;
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        push(0, 8'h77, 1'b1);
        tick();
        rst_set = 1'b1;
        tick();
        n_checks++;
        if (tx_start !== 1'b0 || req_ready !== 3'b000)
            $display("FAIL rst_issue_gate: got tx_start=%b req_ready=%b expected 0 000", tx_start, req_ready);
        else n_pass++;
        clear_queues();
        rst_set = 1'b0;
        tick();
        n_checks++;
        if (grant !== 3'b000 || log_n != 0) $display("FAIL rst_issue_grant: got grant=%b bytes=%0d expected 000 0", grant, log_n);
        else n_pass++;
    endtask

    task automatic test_invariants();
        n_checks++;
        if (viol_busy != 0) $display("FAIL inv_busy_start: got %0d starts while busy expected 0", viol_busy);
        else n_pass++;
        n_checks++;
        if (viol_ready != 0) $display("FAIL inv_ready_owner: got %0d bad ready cycles expected 0", viol_ready);
        else n_pass++;
        n_checks++;
        if (viol_onehot != 0) $display("FAIL inv_grant_onehot: got %0d bad grant cycles expected 0", viol_onehot);
        else n_pass++;
    endtask

    initial begin
        clear_queues();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_gap_timeout();
        test_enable();
        test_reset_wait_lo();
        test_reset_in_issue();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters (2..8).
REQ-002 Parameter GAP_TIMEOUT, default 1024, maximum idle cycles mid-packet before the grant is revoked.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  arbitration enable; low blocks new grants, but a packet in progress completes.
REQ-006 req_valid  in  N_REQ  per-requester byte valid.
REQ-007 req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_last  in  N_REQ  per-requester last byte of the packet; qualified by req_valid.
REQ-009 req_ready  out  N_REQ  per-requester byte accepted; a handshake occurs when valid and ready are both high.
REQ-010 tx_start  out  1  one-cycle start strobe to the UART transmitter.
REQ-011 tx_data  out  8  byte to the transmitter; valid while tx_start is high.
REQ-012 tx_busy  in  1  transmitter busy; rises the cycle after an accepted tx_start and falls after the stop bit.
REQ-013 grant  out  N_REQ  one-hot current owner; all zero when idle.
REQ-014 gap_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-016 In IDLE with en=1 and any req_valid high, grant SHALL register the round-robin winner: the first valid index at or after ptr, wrapping modulo N_REQ; next state ISSUE.
REQ-017 In ISSUE with tx_busy=0 and req_valid[g]=1, the following SHALL be driven combinationally in the same cycle: tx_start=1, tx_data=req_data[g], req_ready[g]=1; req_last[g] is latched; the gap counter is cleared; next state WAIT_HI.
REQ-018 tx_start and req_ready SHALL be asserted only in ISSUE with tx_busy=0, so no byte is offered to a busy transmitter.
REQ-019 In ISSUE with req_valid[g]=0, the gap counter SHALL increment.
REQ-020 When the gap counter reaches GAP_TIMEOUT-1, the block SHALL: clear grant, pulse gap_err, set ptr to (g+1) mod N_REQ, and go to IDLE.
REQ-021 In WAIT_HI the FSM SHALL go to WAIT_LO when tx_busy=1.
REQ-022 In WAIT_LO, when tx_busy=0: if the latched last is set, grant SHALL clear, ptr SHALL become (g+1) mod N_REQ, and the FSM goes to IDLE; otherwise the FSM returns to ISSUE with grant unchanged.
REQ-023 Bytes of one packet SHALL never interleave with another requester's bytes.
REQ-024 Latency from req_valid rising in IDLE to tx_start SHALL be 1 cycle when tx_busy=0.
REQ-025 A non-owner's req_ready SHALL stay 0 for as long as grant is held.
REQ-026 A one-byte packet (valid and last high together) SHALL complete with a single handshake.
REQ-027 A req_valid deasserted after the handshake SHALL not affect the byte already in flight.
REQ-028 The gap counter SHALL be $clog2(GAP_TIMEOUT) bits wide and SHALL saturate, never wrap.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE, with grant=0, ptr=0, gap counter=0, last latch=0, gap_err=0.
REQ-030 While rst is asserted, tx_start=0 and req_ready=0.
REQ-031 A reset mid-packet SHALL abandon the packet; a byte already started in the transmitter is not tracked.

Structure
REQ-032 The package uart_pkg SHALL hold the FSM state enum and the default N_REQ/GAP_TIMEOUT constants.
REQ-033 The round-robin winner selection SHALL be a combinational sub-module rr_pick with inputs req and ptr, and a one-hot win output.
REQ-034 The FSM, gap counter and ptr register SHALL live in uart_tx_arb.
REQ-035 The block SHALL be verified against a behavioural transmitter model honouring REQ-012.

Verification
REQ-036 Single requester: req0 sends a 3-byte packet 0x41, 0x42, 0x43 with last on 0x43 -> three tx_start pulses carrying the bytes in order; the first pulse comes 1 cycle after valid; grant=001 throughout, then 000.
REQ-037 Contention: req0 and req2 are valid together from reset with 2-byte packets -> the req0 packet goes first, then req2; ptr ends at 0; no interleaving.
REQ-038 Fairness: all 3 requesters continuously send 1-byte packets -> grant order is 0, 1, 2, 0, 1, 2.
REQ-039 Gap timeout: GAP_TIMEOUT=8; req1 sends a non-last byte, then drops valid -> gap_err pulses once 8 cycles after re-entering ISSUE; grant clears; req2 is then served.
REQ-040 Enable and reset: en is dropped mid-packet -> the packet completes and no new grant follows until en=1; rst asserted in WAIT_LO -> next cycle grant=0, state IDLE, and no tx_start follows.
